// File: rtl/fp_pkg.sv
// Shared definitions for the float-to-decimal converter: IEEE754 single field layout,
// FSM state encoding and field-extract helpers.
package fp_pkg;

  localparam int EXP_BIAS        = 127;
  localparam int EXP_W           = 8;
  localparam int MANT_W          = 23;
  localparam int FRAC_DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    FRAC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic get_sign(input logic [31:0] w);
    return w[31];
  endfunction

  function automatic logic [EXP_W-1:0] get_exp(input logic [31:0] w);
    return w[30:23];
  endfunction

  // Significand with the hidden leading one restored.
  function automatic logic [MANT_W:0] get_mant(input logic [31:0] w);
    return {1'b1, w[22:0]};
  endfunction

endpackage

// File: rtl/fp_frac_digit.sv
// One decimal digit step: multiply a 0.32 binary fraction by ten, split off the
// integer digit and keep the remaining fraction.
module fp_frac_digit
  import fp_pkg::*;
(
  input  logic [31:0] frac_in,
  output logic [3:0]  digit,
  output logic [31:0] frac_out
);

  logic [35:0] prod_s;

  // x*10 as (x<<3)+(x<<1) keeps this a pair of adders instead of a multiplier.
  always_comb begin
    prod_s   = ({4'd0, frac_in} << 3) + ({4'd0, frac_in} << 1);
    digit    = prod_s[35:32];
    frac_out = prod_s[31:0];
  end

endmodule

// File: rtl/fp_to_dec.sv
// Converts an IEEE754 single into sign, 32-bit integer magnitude and a fixed
// FRAC_DIGITS-digit decimal fraction, with fixed latency for every input.
module fp_to_dec
  import fp_pkg::*;
#(
  parameter int FRAC_DIGITS = FRAC_DIGITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] flt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [31:0] out_int,
  output logic [13:0] out_frac,
  output logic        out_zero,
  output logic        out_ovf
);

  state_t      state_r, state_s;
  logic        sign_r;
  logic [7:0]  exp_r;
  logic [23:0] mant_r;
  logic [31:0] int_r, frac_r;
  logic [13:0] acc_r, acc_next_s;
  logic [7:0]  cnt_r;
  logic        last_s, is_zero_s, is_ovf_s, is_small_s;
  logic [5:0]  shamt_s;
  logic [63:0] aligned_s;
  logic [31:0] int_align_s, frac_align_s, frac_next_s;
  logic [3:0]  digit_s;

  fp_frac_digit u_digit (
    .frac_in  (frac_r),
    .digit    (digit_s),
    .frac_out (frac_next_s)
  );

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_s = ALIGN; else state_s = IDLE;
      ALIGN:   state_s = FRAC;
      FRAC:    if (last_s) state_s = DONE; else state_s = FRAC;
      DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Value = F*2^(e-150); placing F at bit 40 of a 64-bit word gives 32.32 fixed point
  // after one right shift by 158-e, valid for 95 <= e <= 158.
  always_comb begin
    is_zero_s    = (exp_r == 8'd0);
    is_ovf_s     = (exp_r >= 8'd159);
    is_small_s   = (exp_r < 8'd95);
    shamt_s      = 6'd0;
    aligned_s    = 64'd0;
    int_align_s  = 32'd0;
    frac_align_s = 32'd0;
    if (is_zero_s) begin
      int_align_s  = 32'd0;
      frac_align_s = 32'd0;
    end else if (is_ovf_s) begin
      int_align_s  = 32'hFFFF_FFFF;
      frac_align_s = 32'd0;
    end else if (is_small_s) begin
      int_align_s  = 32'd0;
      frac_align_s = 32'd0;
    end else begin
      shamt_s      = 6'(8'd158 - exp_r);
      aligned_s    = {mant_r, 40'd0} >> shamt_s;
      int_align_s  = aligned_s[63:32];
      frac_align_s = aligned_s[31:0];
    end
  end

  // Decimal accumulator update and digit-count terminal condition.
  always_comb begin
    acc_next_s = (acc_r << 3) + (acc_r << 1) + {10'd0, digit_s};
    last_s     = (cnt_r == 8'(FRAC_DIGITS - 1));
  end

  // Datapath registers; outputs load only when the last digit completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_r   <= 1'b0;
      exp_r    <= 8'd0;
      mant_r   <= 24'd0;
      int_r    <= 32'd0;
      frac_r   <= 32'd0;
      acc_r    <= 14'd0;
      cnt_r    <= 8'd0;
      out_sign <= 1'b0;
      out_int  <= 32'd0;
      out_frac <= 14'd0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sign_r <= get_sign(flt);
            exp_r  <= get_exp(flt);
            mant_r <= get_mant(flt);
          end
        end
        ALIGN: begin
          int_r  <= int_align_s;
          frac_r <= frac_align_s;
          acc_r  <= 14'd0;
          cnt_r  <= 8'd0;
        end
        FRAC: begin
          frac_r <= frac_next_s;
          acc_r  <= acc_next_s;
          cnt_r  <= cnt_r + 8'd1;
          if (last_s) begin
            out_sign <= is_zero_s ? 1'b0 : sign_r;
            out_int  <= int_r;
            out_frac <= acc_next_s;
            out_zero <= is_zero_s;
            out_ovf  <= is_ovf_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_dec.sv
// Directed self-checking bench for fp_to_dec: hand-computed conversions, special
// encodings, output back-pressure and reset during an in-flight conversion.
module tb_fp_to_dec;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] flt;
  logic        out_sign, out_zero, out_ovf;
  logic [31:0] out_int;
  logic [13:0] out_frac;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct packed {
    logic [31:0] w;
    logic        sign;
    logic [31:0] iv;
    logic [13:0] fv;
    logic        zero;
    logic        ovf;
  } vec_t;

  fp_to_dec #(.FRAC_DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flt       (flt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_int   (out_int),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Offer one word and count edges from the accepting edge until out_valid.
  task automatic send(input logic [31:0] w, output int lat);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1;
    flt      = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flt      = $urandom;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flt = 32'd0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sign !== 1'b0)   begin n_fail++; $display("FAIL reset_sign: got %b expected 0", out_sign); end
    n_checks++; if (out_int !== 32'd0)   begin n_fail++; $display("FAIL reset_int: got %0d expected 0", out_int); end
    n_checks++; if (out_frac !== 14'd0)  begin n_fail++; $display("FAIL reset_frac: got %0d expected 0", out_frac); end
    n_checks++; if (out_zero !== 1'b0)   begin n_fail++; $display("FAIL reset_zero: got %b expected 0", out_zero); end
    n_checks++; if (out_ovf !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
  endtask

  task automatic test_convert();
    vec_t vecs [10];
    int   lat;
    vecs[0] = '{32'h40500000, 1'b0, 32'd3,          14'd2500, 1'b0, 1'b0};
    vecs[1] = '{32'hBFC00000, 1'b1, 32'd1,          14'd5000, 1'b0, 1'b0};
    vecs[2] = '{32'h3DCCCCCD, 1'b0, 32'd0,          14'd1000, 1'b0, 1'b0};
    vecs[3] = '{32'h4F7FFFFF, 1'b0, 32'd4294967040, 14'd0,    1'b0, 1'b0};
    vecs[4] = '{32'h4F000000, 1'b0, 32'd2147483648, 14'd0,    1'b0, 1'b0};
    vecs[5] = '{32'h4F800000, 1'b0, 32'hFFFFFFFF,   14'd0,    1'b0, 1'b1};
    vecs[6] = '{32'h7FC00000, 1'b0, 32'hFFFFFFFF,   14'd0,    1'b0, 1'b1};
    vecs[7] = '{32'hFF800000, 1'b1, 32'hFFFFFFFF,   14'd0,    1'b0, 1'b1};
    vecs[8] = '{32'h80000000, 1'b0, 32'd0,          14'd0,    1'b1, 1'b0};
    vecs[9] = '{32'h2F000000, 1'b0, 32'd0,          14'd0,    1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].w, lat);
      n_checks++; if (lat !== 5)                  begin n_fail++; $display("FAIL conv%0d_latency: got %0d expected 5", i, lat); end
      n_checks++; if (out_sign !== vecs[i].sign)  begin n_fail++; $display("FAIL conv%0d_sign: got %b expected %b", i, out_sign, vecs[i].sign); end
      n_checks++; if (out_int !== vecs[i].iv)     begin n_fail++; $display("FAIL conv%0d_int: got %0d expected %0d", i, out_int, vecs[i].iv); end
      n_checks++; if (out_frac !== vecs[i].fv)    begin n_fail++; $display("FAIL conv%0d_frac: got %0d expected %0d", i, out_frac, vecs[i].fv); end
      n_checks++; if (out_zero !== vecs[i].zero)  begin n_fail++; $display("FAIL conv%0d_zero: got %b expected %b", i, out_zero, vecs[i].zero); end
      n_checks++; if (out_ovf !== vecs[i].ovf)    begin n_fail++; $display("FAIL conv%0d_ovf: got %b expected %b", i, out_ovf, vecs[i].ovf); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(32'h40500000, lat);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      flt      = $urandom;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL hold%0d_valid: got %b expected 1", c, out_valid); end
      n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL hold%0d_in_ready: got %b expected 0", c, in_ready); end
      n_checks++; if (out_int !== 32'd3)     begin n_fail++; $display("FAIL hold%0d_int: got %0d expected 3", c, out_int); end
      n_checks++; if (out_frac !== 14'd2500) begin n_fail++; $display("FAIL hold%0d_frac: got %0d expected 2500", c, out_frac); end
    end
    in_valid = 1'b0;
    consume();
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL consumed_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL consumed_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_int !== 32'd3)   begin n_fail++; $display("FAIL consumed_int_held: got %0d expected 3", out_int); end
    send(32'hBFC00000, lat);
    n_checks++; if (lat !== 5)             begin n_fail++; $display("FAIL next_latency: got %0d expected 5", lat); end
    n_checks++; if (out_sign !== 1'b1)     begin n_fail++; $display("FAIL next_sign: got %b expected 1", out_sign); end
    n_checks++; if (out_int !== 32'd1)     begin n_fail++; $display("FAIL next_int: got %0d expected 1", out_int); end
    n_checks++; if (out_frac !== 14'd5000) begin n_fail++; $display("FAIL next_frac: got %0d expected 5000", out_frac); end
    consume();
  endtask

  task automatic test_reset_midflight();
    int lat;
    in_valid = 1'b1;
    flt      = 32'h40500000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sign !== 1'b0)  begin n_fail++; $display("FAIL mid_sign: got %b expected 0", out_sign); end
    n_checks++; if (out_int !== 32'd0)  begin n_fail++; $display("FAIL mid_int: got %0d expected 0", out_int); end
    n_checks++; if (out_frac !== 14'd0) begin n_fail++; $display("FAIL mid_frac: got %0d expected 0", out_frac); end
    n_checks++; if (out_zero !== 1'b0)  begin n_fail++; $display("FAIL mid_zero: got %b expected 0", out_zero); end
    n_checks++; if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL mid_ovf: got %b expected 0", out_ovf); end
    send(32'h3DCCCCCD, lat);
    n_checks++; if (lat !== 5)             begin n_fail++; $display("FAIL post_latency: got %0d expected 5", lat); end
    n_checks++; if (out_int !== 32'd0)     begin n_fail++; $display("FAIL post_int: got %0d expected 0", out_int); end
    n_checks++; if (out_frac !== 14'd1000) begin n_fail++; $display("FAIL post_frac: got %0d expected 1000", out_frac); end
    consume();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
